qduc_sample_feeder: RTL and testbench
=====================================

QDUC_SAMPLE_FEEDER -- requirements
Module: qduc_sample_feeder

Interface
REQ-001 The block SHALL have parameter ISZ, default 16: IQ sample word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16: FIFO depth in IQ pairs, a power of 2, minimum 4.
REQ-003 The block SHALL have parameter PRIME_LVL, default 8: FIFO fill level required before streaming starts; range 1..DEPTH.
REQ-004 The block SHALL have port clk, input, 1: sole clock. All logic is on the rising edge.
REQ-005 The block SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 The block SHALL have port enable, input, 1: streaming enable. Low means flush and idle.
REQ-007 The block SHALL have port sample_stb, input, 1: single-cycle sample-rate strobe, nominally clk/64 from the upconverter's first-stage divider.
REQ-008 The block SHALL have port s_valid, input, 1: upstream sample valid.
REQ-009 The block SHALL have port s_ready, output, 1: block can accept a sample this cycle.
REQ-010 The block SHALL have port s_i, input, ISZ, signed: upstream in-phase sample.
REQ-011 The block SHALL have port s_q, input, ISZ, signed: upstream quadrature sample.
REQ-012 The block SHALL have port out_i, output, ISZ, signed: in-phase sample to the upconverter.
REQ-013 The block SHALL have port out_q, output, ISZ, signed: quadrature sample to the upconverter.
REQ-014 The block SHALL have port level, output, clog2(DEPTH)+1: current FIFO occupancy.
REQ-015 The block SHALL have port underrun, output, 1: single-cycle pulse, high when a strobe finds the FIFO empty in RUN.

Function
REQ-016 A push SHALL occur on a cycle with s_valid=1 and s_ready=1; s_ready = !full and state != IDLE.
REQ-017 The FIFO SHALL use wrap-around read and write pointers of clog2(DEPTH)+1 bits. Full means the MSBs differ and the remaining bits are equal; empty means the pointers are equal.
REQ-018 State machine IDLE: out_i/out_q = 0 and the FIFO is flushed. Go to PRIME when enable=1.
REQ-019 State machine PRIME: outputs held at 0 and no pops. Go to RUN on the cycle level >= PRIME_LVL.
REQ-020 State machine RUN: each sample_stb pops one pair. The pair appears on out_i/out_q exactly 1 clk after the strobe and is held until the next strobe.
REQ-021 A strobe in RUN with the FIFO empty SHALL drive outputs to 0 one cycle later, pulse underrun, and return to PRIME.
REQ-022 enable=0 in any state SHALL force IDLE on the next edge: pointers cleared, outputs 0, and any push that cycle discarded.
REQ-023 A simultaneous push and pop SHALL leave level unchanged and preserve order. A push into an empty FIFO on the same cycle as a strobe SHALL NOT be popped by that strobe (underrun applies).
REQ-024 A strobe outside RUN SHALL be ignored.
REQ-025 Sample data SHALL pass bit-exact, with no scaling or rounding.

Reset
REQ-026 While reset=1 the block SHALL hold: state IDLE, pointers 0, out_i=out_q=0, s_ready=0, underrun=0, level=0.
REQ-027 Deassertion of reset SHALL be synchronised by the instantiating design. The first active edge after reset starts in IDLE.

Configuration
REQ-028 With macro QDUC_SAMPLE_FEEDER_UFLOW_CNT_EN defined, the block SHALL add output uflow_cnt[15:0]:
- increments on each underrun pulse
- saturates at 16'hFFFF
- cleared by reset only
REQ-029 Without QDUC_SAMPLE_FEEDER_UFLOW_CNT_EN, the uflow_cnt port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-030 Priming: enable=1, push 8 pairs (i=1..8, q=-1..-8) before any strobe, strobe every 64 clk -> RUN entered when level=8; outputs (1,-1),(2,-2)... each 1 clk after its strobe.
REQ-031 Underrun: prime 8 pairs, then stop pushing and strobe 9 times -> 9th strobe gives out=(0,0), a single underrun pulse, and state PRIME; uflow_cnt=1 when the macro is defined.
REQ-032 Full: DEPTH=16, strobes off, s_valid held high -> s_ready drops after the 16th push; level=16; a 17th sample is not accepted.
REQ-033 Mid-run disable and reset: in RUN with level=5, enable=0 for 1 clk -> next cycle level=0, outputs 0, IDLE. Repeat with async reset asserted mid-cycle -> outputs 0 immediately, without waiting for a clock edge.
REQ-034 Boundary values: push (16'h7FFF, 16'h8000) and (16'h8000, 16'h7FFF) with simultaneous push and pop at level=1 -> bit-exact output, level unchanged, order preserved.

Source files
------------

// File: rtl/qduc_sample_feeder.sv
// IQ sample FIFO feeding the upconverter: primes to PRIME_LVL, then pops one pair per sample strobe.
// Optional QDUC_SAMPLE_FEEDER_UFLOW_CNT_EN adds a saturating 16-bit underrun counter output.
module qduc_sample_feeder #(
    parameter int ISZ       = 16,
    parameter int DEPTH     = 16,
    parameter int PRIME_LVL = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        sample_stb,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic signed [ISZ-1:0]       s_i,
    input  logic signed [ISZ-1:0]       s_q,
    output logic signed [ISZ-1:0]       out_i,
    output logic signed [ISZ-1:0]       out_q,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        underrun
`ifdef QDUC_SAMPLE_FEEDER_UFLOW_CNT_EN
    ,
    output logic [15:0]                 uflow_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PRIME_LVL_W = (AW+1)'(PRIME_LVL);
    localparam logic [AW:0] PTR_ONE     = (AW+1)'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRIME = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    logic [1:0]            r_state;
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic signed [ISZ-1:0] r_mem_i [DEPTH];
    logic signed [ISZ-1:0] r_mem_q [DEPTH];
    logic signed [ISZ-1:0] r_out_i;
    logic signed [ISZ-1:0] r_out_q;
    logic                  r_underrun;

    logic [AW:0] w_level;
    logic        w_full;
    logic        w_empty;
    logic        w_ready;
    logic        w_push;

    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_ready = !w_full && (r_state != S_IDLE);
    assign w_push  = s_valid && w_ready && enable;

    assign s_ready  = w_ready;
    assign out_i    = r_out_i;
    assign out_q    = r_out_q;
    assign level    = w_level;
    assign underrun = r_underrun;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_i[r_wr_ptr[AW-1:0]] <= s_i;
            r_mem_q[r_wr_ptr[AW-1:0]] <= s_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_out_i    <= '0;
            r_out_q    <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (!enable) begin
                r_state  <= S_IDLE;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_out_i  <= '0;
                r_out_q  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                end
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_PRIME;
                    end
                    S_PRIME: begin
                        if (w_level >= PRIME_LVL_W) begin
                            r_state <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        // Emptiness is judged on pre-push pointers, so a same-cycle push is never popped
                        if (sample_stb) begin
                            if (w_empty) begin
                                r_out_i    <= '0;
                                r_out_q    <= '0;
                                r_underrun <= 1'b1;
                                r_state    <= S_PRIME;
                            end else begin
                                r_out_i  <= r_mem_i[r_rd_ptr[AW-1:0]];
                                r_out_q  <= r_mem_q[r_rd_ptr[AW-1:0]];
                                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef QDUC_SAMPLE_FEEDER_UFLOW_CNT_EN
    logic [15:0] r_uflow_cnt;
    logic        w_uflow_evt;

    assign w_uflow_evt = enable && (r_state == S_RUN) && sample_stb && w_empty;
    assign uflow_cnt   = r_uflow_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_uflow_cnt <= '0;
        end else if (w_uflow_evt && (r_uflow_cnt != 16'hFFFF)) begin
            r_uflow_cnt <= r_uflow_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_qduc_sample_feeder.sv
// Directed bench for qduc_sample_feeder: priming, underrun, full, disable/async reset, boundary data.
module tb_qduc_sample_feeder;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               enable = 1'b0;
    logic               sample_stb = 1'b0;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic signed [15:0] s_i = '0;
    logic signed [15:0] s_q = '0;
    logic signed [15:0] out_i;
    logic signed [15:0] out_q;
    logic [4:0]         level;
    logic               underrun;
`ifdef QDUC_SAMPLE_FEEDER_UFLOW_CNT_EN
    logic [15:0]        uflow_cnt;
`endif

    typedef struct packed {
        logic [15:0] i;
        logic [15:0] q;
    } pair_t;

    pair_t              sb[$];
    logic signed [15:0] last_i = '0;
    logic signed [15:0] last_q = '0;
    int                 checks = 0;
    int                 errors = 0;

    qduc_sample_feeder #(.ISZ(16), .DEPTH(16), .PRIME_LVL(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .sample_stb (sample_stb),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_i        (s_i),
        .s_q        (s_q),
        .out_i      (out_i),
        .out_q      (out_q),
        .level      (level),
        .underrun   (underrun)
`ifdef QDUC_SAMPLE_FEEDER_UFLOW_CNT_EN
        ,
        .uflow_cnt  (uflow_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int k);
        pair_t p;
        p.i = 16'(k);
        p.q = 16'(-k);
        s_valid = 1'b1;
        s_i = p.i;
        s_q = p.q;
        chk("push_ready", 32'(s_ready), 32'd1);
        sb.push_back(p);
        tick();
        s_valid = 1'b0;
    endtask

    // Wait gap cycles (output must hold), strobe once, compare against scoreboard or zero on underrun
    task automatic strobe(input int gap, input bit uf);
        pair_t p;
        repeat (gap) tick();
        chk("hold_i", 32'(out_i), 32'(last_i));
        chk("hold_q", 32'(out_q), 32'(last_q));
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        s_valid = 1'b0;
        if (uf) begin
            last_i = '0;
            last_q = '0;
        end else if (sb.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
            p = sb.pop_front();
            last_i = p.i;
            last_q = p.q;
        end
        chk("out_i", 32'(out_i), 32'(last_i));
        chk("out_q", 32'(out_q), 32'(last_q));
        chk("underrun", 32'(underrun), 32'(uf));
    endtask

    initial begin
        int acc;
        // Reset state
        repeat (3) tick();
        chk("rst_out_i", 32'(out_i), 32'd0);
        chk("rst_out_q", 32'(out_q), 32'd0);
        chk("rst_ready", 32'(s_ready), 32'd0);
        chk("rst_uflow", 32'(underrun), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        reset = 1'b0;
        enable = 1'b1;
        tick();
        chk("prime_ready", 32'(s_ready), 32'd1);

        // Priming and streaming
        for (int k = 1; k <= 8; k++) begin
            push(k);
            chk("prime_level", 32'(level), 32'(k));
        end
        for (int k = 1; k <= 8; k++) strobe(63, 1'b0);
        chk("drained_level", 32'(level), 32'd0);

        // Underrun: single pulse, back in PRIME where strobes are ignored
        strobe(63, 1'b1);
        tick();
        chk("uflow_single", 32'(underrun), 32'd0);
`ifdef QDUC_SAMPLE_FEEDER_UFLOW_CNT_EN
        chk("uflow_cnt1", 32'(uflow_cnt), 32'd1);
`endif
        push(50);
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        chk("prime_ign_lvl", 32'(level), 32'd1);
        chk("prime_ign_uf", 32'(underrun), 32'd0);
        chk("prime_ign_out", 32'(out_i), 32'd0);

        // Full: hold s_valid high with strobes off
        acc = 0;
        s_valid = 1'b1;
        for (int k = 0; k < 17; k++) begin
            pair_t p;
            p.i = 16'(100 + k);
            p.q = 16'(-(100 + k));
            s_i = p.i;
            s_q = p.q;
            if (s_ready) begin
                sb.push_back(p);
                acc++;
            end
            tick();
        end
        s_valid = 1'b0;
        chk("full_accepted", 32'(acc), 32'd15);
        chk("full_level", 32'(level), 32'd16);
        chk("full_ready", 32'(s_ready), 32'd0);

        // Drain to level 5, then one-cycle disable with a push that must be discarded
        for (int k = 0; k < 11; k++) strobe(1, 1'b0);
        chk("mid_level", 32'(level), 32'd5);
        enable = 1'b0;
        s_valid = 1'b1;
        s_i = 16'sd77;
        s_q = 16'sd77;
        tick();
        s_valid = 1'b0;
        chk("dis_level", 32'(level), 32'd0);
        chk("dis_out_i", 32'(out_i), 32'd0);
        chk("dis_out_q", 32'(out_q), 32'd0);
        chk("dis_idle", 32'(s_ready), 32'd0);
        enable = 1'b1;
        sb.delete();
        last_i = '0;
        last_q = '0;
        tick();

        // Async reset mid-cycle clears outputs without a clock edge
        for (int k = 200; k < 208; k++) push(k);
        strobe(3, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out_i", 32'(out_i), 32'd0);
        chk("arst_out_q", 32'(out_q), 32'd0);
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_ready", 32'(s_ready), 32'd0);
`ifdef QDUC_SAMPLE_FEEDER_UFLOW_CNT_EN
        chk("arst_ucnt", 32'(uflow_cnt), 32'd0);
`endif
        tick();
        reset = 1'b0;
        sb.delete();
        last_i = '0;
        last_q = '0;
        tick();

        // Boundary values with simultaneous push and pop at level 1
        for (int k = 300; k < 308; k++) push(k);
        for (int k = 0; k < 7; k++) strobe(3, 1'b0);
        chk("bnd_level1", 32'(level), 32'd1);
        begin
            pair_t p;
            p.i = 16'h7FFF;
            p.q = 16'h8000;
            s_valid = 1'b1;
            s_i = p.i;
            s_q = p.q;
            sb.push_back(p);
            strobe(0, 1'b0);
            chk("bnd_level_a", 32'(level), 32'd1);
            p.i = 16'h8000;
            p.q = 16'h7FFF;
            s_valid = 1'b1;
            s_i = p.i;
            s_q = p.q;
            sb.push_back(p);
            strobe(0, 1'b0);
            chk("bnd_level_b", 32'(level), 32'd1);
        end
        strobe(2, 1'b0);
        chk("bnd_level_0", 32'(level), 32'd0);
        strobe(2, 1'b1);
`ifdef QDUC_SAMPLE_FEEDER_UFLOW_CNT_EN
        chk("uflow_cnt_end", 32'(uflow_cnt), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
